// File: rtl/sram22_req_ctrl_if.sv
// sram22_req_ctrl_if
// Bundles the request port, the read-response port and the SRAM macro pins
// of sram22_req_ctrl.
//   slave  : the controller side (accepts requests, returns responses,
//            drives the SRAM macro inputs).
//   master : the requester / environment side (issues requests, consumes
//            responses, supplies the SRAM macro read data).
interface sram22_req_ctrl_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int WMASK_WIDTH = 4
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [WMASK_WIDTH-1:0] req_wmask;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic [DATA_WIDTH-1:0]  req_wdata;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [DATA_WIDTH-1:0]  rsp_rdata;

    logic                   sram_we;
    logic [WMASK_WIDTH-1:0] sram_wmask;
    logic [ADDR_WIDTH-1:0]  sram_addr;
    logic [DATA_WIDTH-1:0]  sram_din;
    logic [DATA_WIDTH-1:0]  sram_dout;

    modport slave (
        input  req_valid, req_we, req_wmask, req_addr, req_wdata,
        input  rsp_ready,
        input  sram_dout,
        output req_ready,
        output rsp_valid, rsp_rdata,
        output sram_we, sram_wmask, sram_addr, sram_din
    );

    modport master (
        output req_valid, req_we, req_wmask, req_addr, req_wdata,
        output rsp_ready,
        output sram_dout,
        input  req_ready,
        input  rsp_valid, rsp_rdata,
        input  sram_we, sram_wmask, sram_addr, sram_din
    );
endinterface

// File: rtl/sram22_req_ctrl.sv
// sram22_req_ctrl
// Valid/ready front end for a single-port SRAM macro with registered read
// data. Requests go straight to the macro pins; read data comes back one
// edge after the read fires and is parked in a 2-entry response FIFO.
// A read is only accepted when a FIFO slot is guaranteed, so the macro
// never needs to be stalled.
// Ports:
//   clk   : single clock (also clocks the SRAM macro)
//   rstb  : asynchronous active-low reset
//   bus   : sram22_req_ctrl_if.slave
//           req_*  request port  (valid/ready, we, wmask, addr, wdata)
//           rsp_*  read response (valid/ready, rdata)
//           sram_* macro pins    (we, wmask, addr, din out; dout in)
module sram22_req_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int WMASK_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rstb,
    sram22_req_ctrl_if.slave    bus
);

    logic [1:0]            count;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  rd_pending;
    logic [DATA_WIDTH-1:0] fifo_mem [2];

    logic                  rsp_valid_int;
    logic                  rsp_fire;
    logic                  req_ready_int;
    logic                  req_fire;
    logic                  rd_fire;
    logic                  capture;
    logic [2:0]            occupancy;

    assign rsp_valid_int = (count != 2'd0);
    assign rsp_fire      = rsp_valid_int & bus.rsp_ready;

    // Slots committed after this edge: stored entries plus the read whose
    // data lands next edge, minus the entry being popped right now.
    // rsp_fire implies count >= 1, so this never underflows.
    assign occupancy     = {1'b0, count} + {2'b00, rd_pending} - {2'b00, rsp_fire};
    assign req_ready_int = (occupancy < 3'd2);

    // rstb gating keeps the macro from being written while in reset.
    assign req_fire      = bus.req_valid & req_ready_int & rstb;
    assign rd_fire       = req_fire & ~bus.req_we;
    assign capture       = rd_pending;

    assign bus.req_ready  = req_ready_int;
    assign bus.rsp_valid  = rsp_valid_int;
    assign bus.rsp_rdata  = fifo_mem[rd_ptr];

    assign bus.sram_we    = req_fire & bus.req_we;
    assign bus.sram_wmask = bus.req_wmask;
    assign bus.sram_addr  = bus.req_addr;
    assign bus.sram_din   = bus.req_wdata;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rd_pending <= 1'b0;
            count      <= 2'd0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
        end else begin
            rd_pending <= rd_fire;
            case ({capture, rsp_fire})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (capture) begin
                wr_ptr <= ~wr_ptr;
            end
            if (rsp_fire) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // Data storage is not reset; contents are only visible while count != 0.
    always_ff @(posedge clk) begin
        if (capture) begin
            fifo_mem[wr_ptr] <= bus.sram_dout;
        end
    end

endmodule

// File: tb/tb_sram22_req_ctrl.sv
module tb_sram22_req_ctrl;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int MW = 4;

    logic clk  = 1'b0;
    logic rstb = 1'b0;

    always #5 clk = ~clk;

    sram22_req_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) bus ();

    sram22_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    // Behavioural SRAM macro: byte-masked write, registered read.
    logic [DW-1:0] sram_arr [1024];
    always @(posedge clk) begin
        if (bus.sram_we) begin
            for (int b = 0; b < MW; b++) begin
                if (bus.sram_wmask[b]) sram_arr[bus.sram_addr][8*b +: 8] <= bus.sram_din[8*b +: 8];
            end
        end
        bus.sram_dout <= sram_arr[bus.sram_addr];
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model and scoreboard
    logic [DW-1:0] ref_mem [1024];
    logic [DW-1:0] exp_q [$];
    int            resp_cnt  = 0;
    int            rd_cnt    = 0;
    int            swe_viol  = 0;
    int            cyc       = 0;

    logic          o_rr, o_rv, o_swe, fired_rd, fired_wr;
    logic [DW-1:0] o_rd;

    task automatic cycle(input logic v, input logic we, input logic [MW-1:0] m,
                         input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rr);
        logic [DW-1:0] e;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_we    = we;
        bus.req_wmask = m;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.rsp_ready = rr;
        #1;
        o_rr     = bus.req_ready;
        o_rv     = bus.rsp_valid;
        o_rd     = bus.rsp_rdata;
        o_swe    = bus.sram_we;
        fired_rd = v & o_rr & ~we;
        fired_wr = v & o_rr & we;
        if (o_swe && !o_rr) swe_viol++;
        if (o_rv && rr) begin
            resp_cnt++;
            if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("rsp_data", o_rd, e);
            end
        end
        if (fired_rd) begin
            exp_q.push_back(ref_mem[a]);
            rd_cnt++;
        end
        if (fired_wr) begin
            for (int b = 0; b < MW; b++)
                if (m[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        end
        cyc++;
    endtask

    typedef struct {
        logic          we;
        logic [MW-1:0] m;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int idx, base_rsp, base_rd, first_c, last_c, nresp, rdy_viol, rv_seen;
        logic [DW-1:0] prev;
        logic have_prev;

        vecs[0] = '{1'b1, 4'hF, 10'd5,   32'hDEADBEEF, 32'h0};
        vecs[1] = '{1'b0, 4'hF, 10'd5,   32'h0,        32'hDEADBEEF};
        vecs[2] = '{1'b1, 4'hF, 10'd7,   32'h11223344, 32'h0};
        vecs[3] = '{1'b1, 4'h5, 10'd7,   32'hAABBCCDD, 32'h0};
        vecs[4] = '{1'b0, 4'hF, 10'd7,   32'h0,        32'h11BB33DD};
        vecs[5] = '{1'b1, 4'hF, 10'h3FF, 32'h12345678, 32'h0};
        vecs[6] = '{1'b1, 4'hA, 10'h3FF, 32'h9ABCDEF0, 32'h0};
        vecs[7] = '{1'b0, 4'hF, 10'h3FF, 32'h0,        32'h9A34DE78};
        vecs[8] = '{1'b1, 4'h0, 10'd5,   32'hFFFFFFFF, 32'h0};
        vecs[9] = '{1'b0, 4'hF, 10'd5,   32'h0,        32'hDEADBEEF};

        // Reset with a write offered: macro must not be written.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_wmask = 4'hF;
        bus.req_addr  = 10'd1;
        bus.req_wdata = 32'h0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset_sram_we", bus.sram_we, 0);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rstb = 1'b1;
        #1;
        check("release_req_ready", bus.req_ready, 1);
        check("release_rsp_valid", bus.rsp_valid, 0);

        // Table-driven single operations
        foreach (vecs[i]) begin
            cycle(1'b1, vecs[i].we, vecs[i].m, vecs[i].a, vecs[i].d, 1'b1);
            check("vec_accept", o_rr, 1);
            check("vec_sram_we", o_swe, vecs[i].we);
            if (!vecs[i].we) begin
                cycle(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1);
                check("vec_lat_edge1_valid", o_rv, 0);
                cycle(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1);
                check("vec_lat_edge2_valid", o_rv, 1);
                check("vec_rdata", o_rd, vecs[i].exp);
            end else begin
                cycle(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1);
            end
        end

        // Read of A followed at once by a write to A returns the old data.
        cycle(1'b1, 1'b0, 4'hF, 10'd5, 32'h0, 1'b1);
        cycle(1'b1, 1'b1, 4'hF, 10'd5, 32'h0BADF00D, 1'b1);
        check("raw_write_accept", fired_wr, 1);
        cycle(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1);
        check("raw_old_data", o_rd, 32'hDEADBEEF);
        cycle(1'b1, 1'b0, 4'hF, 10'd5, 32'h0, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1);
        check("raw_q_empty", exp_q.size(), 0);

        // Backpressure: 4 reads offered with rsp_ready=0
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, 4'hF, AW'(32 + k), 32'hA0000000 + k, 1'b1);
        idx = 0;
        have_prev = 1'b0;
        prev = '0;
        for (int t = 0; t < 6; t++) begin
            cycle(idx < 4, 1'b0, 4'hF, AW'(32 + idx), 32'h0, 1'b0);
            if (fired_rd) idx++;
            if (o_rv) begin
                if (have_prev) check("stall_rdata_hold", o_rd, prev);
                prev = o_rd;
                have_prev = 1'b1;
            end
        end
        check("stall_accepted", idx, 2);
        check("stall_req_ready", o_rr, 0);
        base_rsp = resp_cnt;
        for (int t = 0; t < 20 && (idx < 4 || exp_q.size() != 0); t++) begin
            cycle(idx < 4, 1'b0, 4'hF, AW'(32 + idx), 32'h0, 1'b1);
            if (fired_rd) idx++;
        end
        check("drain_all_accepted", idx, 4);
        check("drain_q_empty", exp_q.size(), 0);
        check("drain_resp_count", resp_cnt - base_rsp, 4);

        // 16 back-to-back reads
        for (int k = 0; k < 16; k++) cycle(1'b1, 1'b1, 4'hF, AW'(64 + k), 32'h50000000 + k * 32'h01010101, 1'b1);
        repeat (2) cycle(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1);
        idx = 0; nresp = 0; first_c = -1; last_c = -1; rdy_viol = 0;
        for (int t = 0; t < 30 && (idx < 16 || exp_q.size() != 0); t++) begin
            cycle(idx < 16, 1'b0, 4'hF, AW'(64 + idx), 32'h0, 1'b1);
            if (idx < 16 && !o_rr) rdy_viol++;
            if (fired_rd) idx++;
            if (o_rv) begin
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                nresp++;
            end
        end
        check("b2b_ready_drops", rdy_viol, 0);
        check("b2b_accepted", idx, 16);
        check("b2b_responses", nresp, 16);
        check("b2b_consecutive", last_c - first_c, 15);

        // Reset with one response held and one read in flight
        cycle(1'b1, 1'b0, 4'hF, 10'd32, 32'h0, 1'b0);
        check("rst_rd1_fire", fired_rd, 1);
        cycle(1'b1, 1'b0, 4'hF, 10'd33, 32'h0, 1'b0);
        check("rst_rd2_fire", fired_rd, 1);
        @(negedge clk);
        check("pre_reset_valid", bus.rsp_valid, 1);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        rstb = 1'b0;
        #1;
        check("reset_drop_valid", bus.rsp_valid, 0);
        check("reset_mid_sram_we", bus.sram_we, 0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rstb = 1'b1;
        exp_q.delete();
        rv_seen = 0;
        for (int t = 0; t < 5; t++) begin
            cycle(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1);
            if (o_rv) rv_seen++;
        end
        check("post_reset_no_rsp", rv_seen, 0);
        check("post_reset_ready", o_rr, 1);

        // Random valid/ready traffic against the reference model
        for (int k = 0; k < 8; k++) cycle(1'b1, 1'b1, 4'hF, AW'(k), $urandom, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1);
        base_rsp = resp_cnt;
        base_rd  = rd_cnt;
        for (int t = 0; t < 400; t++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, MW'($urandom_range(0, 15)),
                  AW'($urandom_range(0, 7)), $urandom, $urandom_range(0, 3) != 0);
        end
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) cycle(1'b0, 1'b0, 4'h0, 10'd0, 32'h0, 1'b1);
        check("rand_q_empty", exp_q.size(), 0);
        check("rand_resp_eq_reads", resp_cnt - base_rsp, rd_cnt - base_rd);
        check("sram_we_without_ready", swe_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sram22_req_ctrl.md
SRAM22_REQ_CTRL -- requirements
Module: sram22_req_ctrl

Interface
REQ-001: Parameter DATA_WIDTH, default 32, data word width.
REQ-002: Parameter ADDR_WIDTH, default 10, word address width.
REQ-003: Parameter WMASK_WIDTH, default 4, byte-lane mask width (DATA_WIDTH/8).
REQ-004: clk  input  1  single clock; also drives the SRAM macro clock.
REQ-005: rstb  input  1  asynchronous active-low reset.
REQ-006: req_valid  input  1  request offered.
REQ-007: req_ready  output  1  request slot available.
REQ-008: req_we  input  1  1=write, 0=read.
REQ-009: req_wmask  input  WMASK_WIDTH  byte-lane enables for writes.
REQ-010: req_addr  input  ADDR_WIDTH  word address.
REQ-011: req_wdata  input  DATA_WIDTH  write data.
REQ-012: rsp_valid  output  1  read data available.
REQ-013: rsp_ready  input  1  consumer accepts read data.
REQ-014: rsp_rdata  output  DATA_WIDTH  read data.
REQ-015: sram_we, sram_wmask, sram_addr, sram_din  outputs  1/WMASK_WIDTH/ADDR_WIDTH/DATA_WIDTH  drive the SRAM macro write enable, mask, address and data inputs.
REQ-016: sram_dout  input  DATA_WIDTH  SRAM macro registered read data.

Function
REQ-017: Request fire = req_valid & req_ready; response fire = rsp_valid & rsp_ready.
REQ-018: SRAM inputs are combinational from the request port: sram_addr=req_addr, sram_din=req_wdata, sram_wmask=req_wmask, sram_we=req_valid & req_ready & req_we.
REQ-019: When no write fires, sram_we is 0; the SRAM then performs a don't-care read, and that data is never captured.
REQ-020: A read fire at edge N sets a 1-bit rd_pending register; sram_dout is captured into the response FIFO at edge N+1, and rd_pending then clears unless another read fires at N+1.
REQ-021: Writes produce no response and never set rd_pending.
REQ-022: The response FIFO holds 2 entries (DATA_WIDTH each) with 2-bit count and 1-bit read/write pointers that wrap modulo 2.
REQ-023: rsp_valid = (count != 0); rsp_rdata = FIFO head entry; both are registered-state outputs with no combinational path from rsp_ready.
REQ-024: Credit rule: req_ready = (count + rd_pending − response fire this cycle) < 2, i.e. a read is never accepted without a guaranteed FIFO slot.
REQ-025: req_ready depends combinationally on rsp_ready (same-cycle slot freeing) and not on req_valid.
REQ-026: A capture and a response fire at the same edge leave count unchanged, write at wr_ptr, pop at rd_ptr, and advance both pointers.
REQ-027: Full (count=2, rd_pending=0, no pop) holds req_ready=0 for reads and writes alike, preserving request order.
REQ-028: Back-to-back reads sustain 1 per cycle while rsp_ready=1; steady-state read latency is request fire to rsp_valid = 1 cycle after capture (2 edges).
REQ-029: Read data order equals read request order; a write to address A accepted after a read of A does not affect that read's data.
REQ-030: While rsp_valid=1 and rsp_ready=0, rsp_rdata holds stable.

Reset
REQ-031: rstb low asynchronously clears count, pointers and rd_pending; rsp_valid=0; req_ready=1 after reset release.
REQ-032: Reset mid-operation discards the in-flight read and FIFO contents; SRAM array contents are not affected by the block.
REQ-033: During reset, sram_we=0 regardless of req_valid.
REQ-034: FIFO data storage has no reset; rsp_rdata is don't-care while rsp_valid=0.

Verification
REQ-035: Write 0xDEADBEEF to addr 5 with wmask=4'hF, then read addr 5 -> rsp_valid 2 edges after the read fire, rsp_rdata=0xDEADBEEF.
REQ-036: Write 0x11223344 to addr 7, then write 0xAABBCCDD with wmask=4'b0101, then read addr 7 -> rsp_rdata=0x11BB33DD.
REQ-037: rsp_ready=0 while issuing 4 reads -> exactly 2 reads accepted and req_ready=0; raise rsp_ready -> data returns in order and the remaining reads are accepted.
REQ-038: 16 back-to-back reads of preloaded addresses with rsp_ready=1 -> req_ready stays 1 and 16 in-order responses are delivered on consecutive cycles.
REQ-039: Assert rstb=0 one cycle after a read fire -> rsp_valid=0 immediately, no response is delivered after release, and req_ready=1.
REQ-040: Random valid/ready stimulus checked against a reference memory model -> no dropped or duplicated responses and no write reported by sram_we while req_ready=0.
